// File: rtl/cmat_pkg.sv
// Shared definitions for the 2x2 complex matrix multiplier: widths, FSM encoding
// and the element packing order (x00, x01, x10, x11 from LSB).
package cmat_pkg;

    localparam int unsigned CMAT_DW = 8;
    localparam int unsigned CMAT_PW = 2 * CMAT_DW + 1;
    localparam int unsigned CMAT_AW = 2 * CMAT_DW + 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Element index within a packed matrix bus is {row, col}
    localparam logic [1:0] E00 = 2'd0;
    localparam logic [1:0] E01 = 2'd1;
    localparam logic [1:0] E10 = 2'd2;
    localparam logic [1:0] E11 = 2'd3;

endpackage

// File: rtl/cplx_mul.sv
// Combinational signed complex multiplier; full-precision PW-bit result components.
module cplx_mul
    import cmat_pkg::*;
#(
    parameter int unsigned DW = CMAT_DW,
    localparam int unsigned PW = 2 * DW + 1
) (
    input  logic signed [DW-1:0] ar,
    input  logic signed [DW-1:0] ai,
    input  logic signed [DW-1:0] br,
    input  logic signed [DW-1:0] bi,
    output logic signed [PW-1:0] p_re,
    output logic signed [PW-1:0] p_im
);

    logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;

    assign ar_x = {{(PW-DW){ar[DW-1]}}, ar};
    assign ai_x = {{(PW-DW){ai[DW-1]}}, ai};
    assign br_x = {{(PW-DW){br[DW-1]}}, br};
    assign bi_x = {{(PW-DW){bi[DW-1]}}, bi};

    assign p_re = ar_x * br_x - ai_x * bi_x;
    assign p_im = ar_x * bi_x + ai_x * br_x;

endmodule

// File: rtl/cmat2x2_mul_seq.sv
// Sequential 2x2 complex matrix multiply C = A x B, one element product per cycle
// through a shared cplx_mul, result presented on a valid/ready output.
module cmat2x2_mul_seq
    import cmat_pkg::*;
#(
    parameter int unsigned DW = CMAT_DW,
    localparam int unsigned PW = 2 * DW + 1,
    localparam int unsigned AW = 2 * DW + 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4*DW-1:0] a_re,
    input  logic [4*DW-1:0] a_im,
    input  logic [4*DW-1:0] b_re,
    input  logic [4*DW-1:0] b_im,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4*AW-1:0] c_re,
    output logic [4*AW-1:0] c_im
);

    logic [1:0]           state_q, state_d;
    logic [2:0]           cnt_q;
    logic [4*DW-1:0]      ar_q, ai_q, br_q, bi_q;
    logic signed [AW-1:0] acc_re_q, acc_im_q;
    logic [4*AW-1:0]      c_re_q, c_im_q;

    logic                 row, col, kk;
    logic [1:0]           a_idx, b_idx, c_idx;
    logic signed [DW-1:0] sel_ar, sel_ai, sel_br, sel_bi;
    logic signed [PW-1:0] p_re, p_im;
    logic signed [AW-1:0] p_re_x, p_im_x;

    // cnt = {i, j, k}: product A[i][k] x B[k][j], accumulated over k into C[i][j]
    assign {row, col, kk} = cnt_q;
    assign a_idx = {row, kk};
    assign b_idx = {kk, col};
    assign c_idx = {row, col};

    always_comb begin
        sel_ar = ar_q[a_idx*DW +: DW];
        sel_ai = ai_q[a_idx*DW +: DW];
        sel_br = br_q[b_idx*DW +: DW];
        sel_bi = bi_q[b_idx*DW +: DW];
    end

    cplx_mul #(
        .DW(DW)
    ) u_mul (
        .ar  (sel_ar),
        .ai  (sel_ai),
        .br  (sel_br),
        .bi  (sel_bi),
        .p_re(p_re),
        .p_im(p_im)
    );

    assign p_re_x = {{(AW-PW){p_re[PW-1]}}, p_re};
    assign p_im_x = {{(AW-PW){p_im[PW-1]}}, p_im};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = CALC;
            CALC:    if (c_idx == E11 && kk) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ar_q     <= '0;
            ai_q     <= '0;
            br_q     <= '0;
            bi_q     <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            c_re_q   <= '0;
            c_im_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                ar_q  <= a_re;
                ai_q  <= a_im;
                br_q  <= b_re;
                bi_q  <= b_im;
                cnt_q <= '0;
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q + 3'd1;
                if (!kk) begin
                    acc_re_q <= p_re_x;
                    acc_im_q <= p_im_x;
                end else begin
                    c_re_q[c_idx*AW +: AW] <= acc_re_q + p_re_x;
                    c_im_q[c_idx*AW +: AW] <= acc_im_q + p_im_x;
                end
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign c_re      = c_re_q;
    assign c_im      = c_im_q;

endmodule

// File: tb/tb_cmat2x2_mul_seq.sv
// Self-checking bench for cmat2x2_mul_seq: directed and random matrices against an
// integer matrix-product model.
module tb_cmat2x2_mul_seq;

    localparam int DW = 8;
    localparam int AW = 2 * DW + 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic            in_ready, out_valid;
    logic [4*DW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic [4*AW-1:0] c_re, c_im;

    int checks = 0;
    int passed = 0;

    int mar[4], mai[4], mbr[4], mbi[4];
    logic [4*AW-1:0] exp_re, exp_im;

    cmat2x2_mul_seq #(
        .DW(DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_re     (a_re),
        .a_im     (a_im),
        .b_re     (b_re),
        .b_im     (b_im),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .c_re     (c_re),
        .c_im     (c_im)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops();
        for (int e = 0; e < 4; e++) begin
            a_re[e*DW +: DW] = DW'(mar[e]);
            a_im[e*DW +: DW] = DW'(mai[e]);
            b_re[e*DW +: DW] = DW'(mbr[e]);
            b_im[e*DW +: DW] = DW'(mbi[e]);
        end
    endtask

    // Reference: plain complex matrix product over integers
    task automatic model();
        int sr, si;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                sr = 0;
                si = 0;
                for (int k = 0; k < 2; k++) begin
                    sr += mar[i*2+k] * mbr[k*2+j] - mai[i*2+k] * mbi[k*2+j];
                    si += mar[i*2+k] * mbi[k*2+j] + mai[i*2+k] * mbr[k*2+j];
                end
                exp_re[(i*2+j)*AW +: AW] = AW'(sr);
                exp_im[(i*2+j)*AW +: AW] = AW'(si);
            end
        end
    endtask

    task automatic rand_ops();
        for (int e = 0; e < 4; e++) begin
            mar[e] = int'($urandom_range(255)) - 128;
            mai[e] = int'($urandom_range(255)) - 128;
            mbr[e] = int'($urandom_range(255)) - 128;
            mbi[e] = int'($urandom_range(255)) - 128;
        end
    endtask

    task automatic do_accept(output bit ok);
        ok = 1'b0;
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (in_ready) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    // Cycles from accept until out_valid (-1 on timeout); flags in_ready seen high meanwhile
    task automatic wait_out(output int lat, output bit rdy_hi);
        lat = -1;
        rdy_hi = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (in_ready) rdy_hi = 1'b1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (c_re !== '0 || c_im !== '0) $display("FAIL reset_c: got %h/%h want 0", c_re, c_im); else passed++;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL idle_out_ready_ignored: got v=%b r=%b want v=0 r=1", out_valid, in_ready); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_diag();
        bit ok, rh;
        int lat;
        mar = '{2, 0, 0, 1}; mai = '{3, 0, 0, 1};
        mbr = '{4, 0, 0, 1}; mbi = '{5, 0, 0, 1};
        set_ops(); model();
        out_ready = 1'b1;
        do_accept(ok);
        checks++; if (!ok) $display("FAIL diag_accept: got timeout want accept"); else passed++;
        wait_out(lat, rh);
        checks++; if (lat != 8) $display("FAIL diag_latency: got %0d want 8", lat); else passed++;
        checks++; if (c_re !== exp_re || c_im !== exp_im) $display("FAIL diag_c: got %h/%h want %h/%h", c_re, c_im, exp_re, exp_im); else passed++;
        checks++; if ($signed(c_re[AW-1:0]) != -7 || $signed(c_im[AW-1:0]) != 22) $display("FAIL diag_c00: got %0d/%0d want -7/22", $signed(c_re[AW-1:0]), $signed(c_im[AW-1:0])); else passed++;
        step();
        checks++; if (out_valid !== 1'b0) $display("FAIL diag_valid_pulse: got %b want 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL diag_ready_back: got %b want 1", in_ready); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_identity();
        bit ok, rh, rh2;
        int lat;
        mar = '{1, 0, 0, 1}; mai = '{0, 0, 0, 0};
        mbr = '{1, 3, -5, 7}; mbi = '{2, -4, 6, 8};
        set_ops(); model();
        do_accept(ok);
        wait_out(lat, rh);
        checks++; if (lat != 8) $display("FAIL ident_latency: got %0d want 8", lat); else passed++;
        rh2 = rh;
        repeat (2) begin
            step();
            if (in_ready) rh2 = 1'b1;
        end
        checks++; if (rh2) $display("FAIL ident_in_ready_low: got 1 want 0 until handshake"); else passed++;
        checks++; if (c_re !== exp_re || c_im !== exp_im) $display("FAIL ident_c: got %h/%h want %h/%h", c_re, c_im, exp_re, exp_im); else passed++;
        out_ready = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL ident_handshake: got r=%b v=%b want r=1 v=0", in_ready, out_valid); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_extreme();
        bit ok, rh;
        int lat;
        mar = '{-128, -128, -128, -128}; mai = '{-128, -128, -128, -128};
        mbr = '{-128, -128, -128, -128}; mbi = '{-128, -128, -128, -128};
        set_ops(); model();
        out_ready = 1'b1;
        do_accept(ok);
        wait_out(lat, rh);
        checks++; if (c_re !== exp_re || c_im !== exp_im) $display("FAIL extreme_c: got %h/%h want %h/%h", c_re, c_im, exp_re, exp_im); else passed++;
        checks++; if (c_im[3*AW +: AW] !== 18'd65536 || c_re[3*AW +: AW] !== 18'd0) $display("FAIL extreme_c11: got %h/%h want 0/10000", c_re[3*AW +: AW], c_im[3*AW +: AW]); else passed++;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        bit ok, rh, stable;
        int lat;
        logic [4*AW-1:0] first_re, first_im;
        rand_ops(); set_ops(); model();
        first_re = exp_re;
        first_im = exp_im;
        do_accept(ok);
        wait_out(lat, rh);
        rand_ops(); set_ops();
        in_valid = 1'b1;
        stable = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            if (!out_valid || c_re !== first_re || c_im !== first_im || in_ready) stable = 1'b0;
        end
        checks++; if (!stable) $display("FAIL stall_hold: got change want stable c=%h/%h", first_re, first_im); else passed++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL stall_handshake: got v=%b r=%b want v=0 r=1", out_valid, in_ready); else passed++;
        checks++; if (c_re !== first_re || c_im !== first_im) $display("FAIL stall_keep: got %h/%h want %h/%h", c_re, c_im, first_re, first_im); else passed++;
    endtask

    task automatic test_midreset();
        bit ok, rh, spurious;
        int lat;
        mar = '{2, 0, 0, 1}; mai = '{3, 0, 0, 1};
        mbr = '{4, 0, 0, 1}; mbi = '{5, 0, 0, 1};
        set_ops(); model();
        out_ready = 1'b1;
        do_accept(ok);
        repeat (4) step();
        #2 rst = 1'b1;
        #1;
        checks++; if (c_re !== '0 || c_im !== '0) $display("FAIL midrst_c: got %h/%h want 0", c_re, c_im); else passed++;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL midrst_flags: got v=%b r=%b want v=0 r=1", out_valid, in_ready); else passed++;
        @(negedge clk);
        rst = 1'b0;
        spurious = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (out_valid) spurious = 1'b1;
        end
        checks++; if (spurious) $display("FAIL midrst_no_partial: got out_valid=1 want 0"); else passed++;
        do_accept(ok);
        wait_out(lat, rh);
        checks++; if (lat != 8) $display("FAIL midrst_latency: got %0d want 8", lat); else passed++;
        checks++; if (c_re !== exp_re || c_im !== exp_im) $display("FAIL midrst_c_after: got %h/%h want %h/%h", c_re, c_im, exp_re, exp_im); else passed++;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4*AW-1:0] q_re[3], q_im[3];
        int accepted, got, last, cyc;
        bit take;
        accepted = 0; got = 0; last = 0; cyc = 0;
        rand_ops(); set_ops(); model();
        q_re[0] = exp_re; q_im[0] = exp_im;
        out_ready = 1'b1;
        in_valid = 1'b1;
        while (cyc < 80 && got < 3) begin
            if (out_valid) begin
                checks++; if (c_re !== q_re[got] || c_im !== q_im[got]) $display("FAIL b2b_c%0d: got %h/%h want %h/%h", got, c_re, c_im, q_re[got], q_im[got]); else passed++;
                if (got > 0) begin
                    checks++; if (cyc - last != 10) $display("FAIL b2b_spacing%0d: got %0d want 10", got, cyc - last); else passed++;
                end
                last = cyc;
                got++;
            end
            take = in_ready && in_valid;
            step();
            cyc++;
            if (take) begin
                accepted++;
                if (accepted < 3) begin
                    rand_ops(); set_ops(); model();
                    q_re[accepted] = exp_re; q_im[accepted] = exp_im;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (got != 3) $display("FAIL b2b_count: got %0d want 3", got); else passed++;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        bit ok, rh, held;
        int lat;
        for (int t = 0; t < 3; t++) begin
            rand_ops(); set_ops(); model();
            do_accept(ok);
            wait_out(lat, rh);
            checks++; if (lat != 8) $display("FAIL rand%0d_latency: got %0d want 8", t, lat); else passed++;
            held = 1'b1;
            repeat ($urandom_range(3)) begin
                step();
                if (!out_valid) held = 1'b0;
            end
            out_ready = 1'b1;
            checks++; if (!held || c_re !== exp_re || c_im !== exp_im) $display("FAIL rand%0d_c: got %h/%h held=%b want %h/%h", t, c_re, c_im, held, exp_re, exp_im); else passed++;
            step();
            out_ready = 1'b0;
            checks++; if (out_valid !== 1'b0) $display("FAIL rand%0d_drop: got %b want 0", t, out_valid); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_diag();
        test_identity();
        test_extreme();
        test_stall();
        test_midreset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
